// File: rtl/ramp_pkg.sv
// Shared types and constants for the multi-channel ramp table player.
// Holds the sequencer state/mode encodings and the mode decode helper.
package ramp_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT    = 2'd0,
        MODE_CONTINUOUS = 2'd1,
        MODE_TRIGGERED  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    // Cycles from an accepted tick to its dout_valid strobe.
    localparam int RD_LAT = 2;

    // The reserved encoding behaves as a one-shot run.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_CONTINUOUS;
            2'd2:    return MODE_TRIGGERED;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/ramp_table_player_if.sv
// Control, table-write and setpoint-output bundle of the ramp player.
// master drives tables and controls; slave is the player itself.
interface ramp_table_player_if #(
    parameter int NUM_CHAN = 4,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 20,
    parameter int CHAN_W   = 2
);
    logic                       wr_en;
    logic [CHAN_W-1:0]          wr_chan;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [ADDR_W-1:0]          ramp_len;
    logic [1:0]                 mode;
    logic                       run;
    logic                       abort;
    logic                       trig;
    logic                       tick;
    logic [NUM_CHAN*DATA_W-1:0] dout;
    logic                       dout_valid;
    logic                       active;
    logic                       done;
    logic [ADDR_W-1:0]          cur_addr;

    modport master (
        output wr_en, wr_chan, wr_addr, wr_data,
        output ramp_len, mode, run, abort, trig, tick,
        input  dout, dout_valid, active, done, cur_addr
    );

    modport slave (
        input  wr_en, wr_chan, wr_addr, wr_data,
        input  ramp_len, mode, run, abort, trig, tick,
        output dout, dout_valid, active, done, cur_addr
    );
endinterface

// File: rtl/ramp_table_ram.sv
// One channel's setpoint table: simple dual-port, read-first,
// registered read. Contents are deliberately not reset.
module ramp_table_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write and read share the edge; the read sees the old word.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) q <= mem[ra];
    end
endmodule

// File: rtl/ramp_table_player.sv
// Multi-channel setpoint ramp sequencer: one table per channel,
// all channels played in lock-step on the sample tick.
module ramp_table_player #(
    parameter int NUM_CHAN = 4,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 20,
    parameter int CHAN_W   = 2
) (
    input logic                clk,
    input logic                reset,
    ramp_table_player_if.slave bus
);
    import ramp_pkg::*;

    state_t                     state, state_n;
    mode_t                      mode_q, mode_in;
    logic                       run_q, start, rd_en, last_hit, cont;
    logic [ADDR_W-1:0]          len_q, rd_addr, addr_p, cur_addr_r;
    logic [RD_LAT-1:0]          vld_sr, last_sr;
    logic [NUM_CHAN*DATA_W-1:0] ram_q, dout_r;

    assign start    = bus.run & ~run_q;
    assign mode_in  = decode_mode(bus.mode);
    assign cont     = (mode_q == MODE_CONTINUOUS);
    assign last_hit = (rd_addr == len_q);
    assign rd_en    = (state == ST_PLAY) & bus.tick & ~bus.abort;

    assign bus.dout       = dout_r;
    assign bus.cur_addr   = cur_addr_r;
    assign bus.dout_valid = vld_sr[RD_LAT-1];
    assign bus.done       = last_sr[RD_LAT-1];
    assign bus.active     = (state != ST_IDLE);

    for (genvar n = 0; n < NUM_CHAN; n++) begin : g_chan
        ramp_table_ram #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_ram (
            .clk(clk),
            .we (bus.wr_en && (bus.wr_chan == CHAN_W'(n))),
            .wa (bus.wr_addr),
            .wd (bus.wr_data),
            .re (rd_en),
            .ra (rd_addr),
            .q  (ram_q[n*DATA_W +: DATA_W])
        );
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state; abort overrides every other event.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode_in == MODE_TRIGGERED) state_n = ST_ARMED;
                    else                           state_n = ST_PLAY;
                end
            end
            ST_ARMED: if (bus.trig) state_n = ST_PLAY;
            ST_PLAY:  if (rd_en && last_hit && !cont) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
        if (bus.abort) state_n = ST_IDLE;
    end

    // Run edge detect, shadow config captured at start, read address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            mode_q  <= MODE_ONESHOT;
            len_q   <= '0;
            rd_addr <= '0;
        end else begin
            run_q <= bus.run;
            if (state == ST_IDLE && start && !bus.abort) begin
                mode_q  <= mode_in;
                len_q   <= bus.ramp_len;
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_addr <= last_hit ? '0 : rd_addr + ADDR_W'(1);
            end
        end
    end

    // Output pipeline: in-flight reads complete even after abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_sr     <= '0;
            last_sr    <= '0;
            addr_p     <= '0;
            dout_r     <= '0;
            cur_addr_r <= '0;
        end else begin
            vld_sr  <= {vld_sr[RD_LAT-2:0], rd_en};
            last_sr <= {last_sr[RD_LAT-2:0], rd_en & last_hit & ~cont};
            if (rd_en) addr_p <= rd_addr;
            if (vld_sr[RD_LAT-2]) begin
                dout_r     <= ram_q;
                cur_addr_r <= addr_p;
            end
        end
    end
endmodule

// File: tb/tb_ramp_table_player.sv
// Self-checking bench for ramp_table_player with a table/run model.
// Scenario tasks are called in sequence from one initial block.
module tb_ramp_table_player;
    localparam int NUM_CHAN = 4;
    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 20;
    localparam int CHAN_W   = 2;
    localparam int MDEPTH   = 128;
    localparam int W        = NUM_CHAN * DATA_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ramp_table_player_if #(
        .NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .CHAN_W(CHAN_W)
    ) bus ();

    ramp_table_player #(
        .NUM_CHAN(NUM_CHAN), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .CHAN_W(CHAN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] tbl [NUM_CHAN][MDEPTH];

    int                w_nv;
    int                w_nd;
    logic              w_done_ok;
    logic [W-1:0]      w_dout;
    logic [ADDR_W-1:0] w_addr;

    function automatic logic [W-1:0] exp_word(input int a);
        logic [W-1:0] v;
        v = '0;
        for (int n = 0; n < NUM_CHAN; n++) v[n*DATA_W +: DATA_W] = tbl[n][a];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] ch_of(input logic [W-1:0] v, input int n);
        return v[n*DATA_W +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.wr_chan  = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.ramp_len = '0;
        bus.mode     = 2'd0;
        bus.run      = 1'b0;
        bus.abort    = 1'b0;
        bus.trig     = 1'b0;
        bus.tick     = 1'b0;
    endtask

    task automatic wr(input int ch, input int a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_chan = CHAN_W'(ch);
        bus.wr_addr = ADDR_W'(a);
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (ch < NUM_CHAN) tbl[ch][a] = d;
    endtask

    task automatic start_run(input logic [1:0] m, input int len);
        bus.mode     = m;
        bus.ramp_len = ADDR_W'(len);
        bus.run      = 1'b1;
        step();
        bus.run = 1'b0;
        step();
    endtask

    task automatic clr_win();
        w_nv      = 0;
        w_nd      = 0;
        w_done_ok = 1'b1;
    endtask

    task automatic sample_win(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            if (bus.dout_valid === 1'b1) begin
                w_nv++;
                w_dout = bus.dout;
                w_addr = bus.cur_addr;
            end
            if (bus.done === 1'b1) begin
                w_nd++;
                if (bus.dout_valid !== 1'b1) w_done_ok = 1'b0;
            end
        end
    endtask

    task automatic tick_win(input int gap);
        clr_win();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        sample_win(gap - 1);
    endtask

    task automatic abort_clean();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.dout !== '0) $display("FAIL reset_dout got %h want 0", bus.dout);
        else passes++;
        checks++;
        if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.dout_valid);
        else passes++;
        checks++;
        if (bus.active !== 1'b0) $display("FAIL reset_active got %b want 0", bus.active);
        else passes++;
        checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
        else passes++;
        checks++;
        if (bus.cur_addr !== '0) $display("FAIL reset_cur_addr got %0d want 0", bus.cur_addr);
        else passes++;
        reset = 1'b0;
        step();
    endtask

    task automatic fill_tables();
        for (int n = 0; n < NUM_CHAN; n++)
            for (int i = 0; i < MDEPTH; i++)
                wr(n, i, DATA_W'(n * 1000 + i));
    endtask

    task automatic test_oneshot();
        start_run(2'd0, 100);
        checks++;
        if (bus.active !== 1'b1) $display("FAIL os_active_start got %b want 1", bus.active);
        else passes++;
        for (int i = 0; i <= 100; i++) begin
            tick_win(10);
            checks++;
            if (w_nv !== 1) $display("FAIL os_strobes i=%0d got %0d want 1", i, w_nv);
            else passes++;
            checks++;
            if (ch_of(w_dout, 2) !== DATA_W'(2000 + i))
                $display("FAIL os_chan2 i=%0d got %0d want %0d", i, ch_of(w_dout, 2), 2000 + i);
            else passes++;
            checks++;
            if (w_dout !== exp_word(i) || w_addr !== ADDR_W'(i))
                $display("FAIL os_word i=%0d got %h@%0d want %h@%0d", i, w_dout, w_addr, exp_word(i), i);
            else passes++;
            checks++;
            if (w_nd !== ((i == 100) ? 1 : 0) || w_done_ok !== 1'b1)
                $display("FAIL os_done i=%0d got %0d aligned=%b want %0d", i, w_nd, w_done_ok, (i == 100) ? 1 : 0);
            else passes++;
        end
        checks++;
        if (bus.active !== 1'b0) $display("FAIL os_active_end got %b want 0", bus.active);
        else passes++;
        tick_win(10);
        checks++;
        if (w_nv !== 0) $display("FAIL os_extra_tick got %0d strobes want 0", w_nv);
        else passes++;
    endtask

    task automatic test_continuous();
        start_run(2'd1, 3);
        for (int i = 0; i < 10; i++) begin
            tick_win(int'($urandom_range(2, 6)));
            checks++;
            if (w_nv !== 1 || w_addr !== ADDR_W'(i % 4) || w_dout !== exp_word(i % 4))
                $display("FAIL cont_seq i=%0d got n=%0d %h@%0d want %h@%0d", i, w_nv, w_dout, w_addr, exp_word(i % 4), i % 4);
            else passes++;
            checks++;
            if (w_nd !== 0 || bus.active !== 1'b1)
                $display("FAIL cont_flags i=%0d got done=%0d active=%b want 0/1", i, w_nd, bus.active);
            else passes++;
        end
        abort_clean();
    endtask

    task automatic test_len_zero();
        start_run(2'd1, 0);
        for (int i = 0; i < 4; i++) begin
            tick_win(int'($urandom_range(2, 5)));
            checks++;
            if (w_nv !== 1 || w_addr !== '0 || w_dout !== exp_word(0))
                $display("FAIL len0 i=%0d got n=%0d %h@%0d want %h@0", i, w_nv, w_dout, w_addr, exp_word(0));
            else passes++;
        end
        abort_clean();
    endtask

    task automatic test_triggered();
        start_run(2'd2, 3);
        checks++;
        if (bus.active !== 1'b1) $display("FAIL trg_armed_active got %b want 1", bus.active);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            tick_win(6);
            checks++;
            if (w_nv !== 0) $display("FAIL trg_armed_tick i=%0d got %0d strobes want 0", i, w_nv);
            else passes++;
        end
        clr_win();
        bus.trig = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.trig = 1'b0;
        bus.tick = 1'b0;
        sample_win(6);
        checks++;
        if (w_nv !== 0) $display("FAIL trg_same_cycle_tick got %0d strobes want 0", w_nv);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            tick_win(6);
            checks++;
            if (w_nv !== 1 || w_addr !== ADDR_W'(i) || w_dout !== exp_word(i))
                $display("FAIL trg_play i=%0d got n=%0d %h@%0d want %h@%0d", i, w_nv, w_dout, w_addr, exp_word(i), i);
            else passes++;
            checks++;
            if (w_nd !== ((i == 3) ? 1 : 0) || w_done_ok !== 1'b1)
                $display("FAIL trg_done i=%0d got %0d want %0d", i, w_nd, (i == 3) ? 1 : 0);
            else passes++;
        end
        checks++;
        if (bus.active !== 1'b0) $display("FAIL trg_active_end got %b want 0", bus.active);
        else passes++;
    endtask

    task automatic test_abort();
        int len;
        len = int'($urandom_range(8, 30));
        start_run(2'd1, len);
        for (int i = 0; i < 5; i++) begin
            tick_win(8);
            checks++;
            if (w_nv !== 1 || w_addr !== ADDR_W'(i))
                $display("FAIL abort_pre i=%0d got n=%0d @%0d want 1 @%0d", i, w_nv, w_addr, i);
            else passes++;
        end
        clr_win();
        bus.tick = 1'b1;
        step();
        bus.tick  = 1'b0;
        bus.abort = 1'b1;
        sample_win(1);
        bus.abort = 1'b0;
        sample_win(6);
        checks++;
        if (w_nv !== 1 || w_addr !== ADDR_W'(5) || w_dout !== exp_word(5))
            $display("FAIL abort_inflight got n=%0d %h@%0d want 1 %h@5", w_nv, w_dout, w_addr, exp_word(5));
        else passes++;
        checks++;
        if (w_nd !== 0 || bus.active !== 1'b0)
            $display("FAIL abort_state got done=%0d active=%b want 0/0", w_nd, bus.active);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            tick_win(6);
            checks++;
            if (w_nv !== 0 || w_nd !== 0 || bus.dout !== exp_word(5))
                $display("FAIL abort_after i=%0d got n=%0d done=%0d dout=%h want 0/0/%h", i, w_nv, w_nd, bus.dout, exp_word(5));
            else passes++;
        end
    endtask

    task automatic test_collision();
        logic [1:0]        m;
        logic [DATA_W-1:0] old;
        m = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        start_run(m, 10);
        for (int i = 0; i < 7; i++) tick_win(4);
        old = tbl[0][7];
        clr_win();
        bus.tick    = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_chan = '0;
        bus.wr_addr = ADDR_W'(7);
        bus.wr_data = 20'hABCDE;
        step();
        bus.tick  = 1'b0;
        bus.wr_en = 1'b0;
        tbl[0][7] = 20'hABCDE;
        sample_win(3);
        checks++;
        if (w_nv !== 1 || ch_of(w_dout, 0) !== old || w_addr !== ADDR_W'(7))
            $display("FAIL coll_read_first got n=%0d %h@%0d want %h@7", w_nv, ch_of(w_dout, 0), w_addr, old);
        else passes++;
        for (int i = 8; i <= 10; i++) tick_win(4);
        checks++;
        if (w_nd !== 1 || bus.active !== 1'b0)
            $display("FAIL coll_done got done=%0d active=%b want 1/0", w_nd, bus.active);
        else passes++;
        start_run(m, 10);
        for (int i = 0; i <= 7; i++) tick_win(4);
        checks++;
        if (ch_of(w_dout, 0) !== 20'hABCDE || w_addr !== ADDR_W'(7))
            $display("FAIL coll_new_pass got %h@%0d want abcde@7", ch_of(w_dout, 0), w_addr);
        else passes++;
        for (int i = 8; i <= 10; i++) tick_win(4);
    endtask

    task automatic test_reset_midrun();
        start_run(2'd0, 60);
        for (int i = 0; i <= 40; i++) tick_win(2);
        checks++;
        if (w_nv !== 1 || w_addr !== ADDR_W'(40))
            $display("FAIL rst_pre got n=%0d @%0d want 1 @40", w_nv, w_addr);
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.dout !== '0 || bus.cur_addr !== '0 || bus.active !== 1'b0)
            $display("FAIL rst_mid_async got dout=%h addr=%0d active=%b want 0", bus.dout, bus.cur_addr, bus.active);
        else passes++;
        step();
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.done !== 1'b0 || bus.dout !== '0)
            $display("FAIL rst_mid_hold got valid=%b done=%b dout=%h want 0", bus.dout_valid, bus.done, bus.dout);
        else passes++;
        reset = 1'b0;
        step();
        start_run(2'd0, 5);
        tick_win(4);
        checks++;
        if (w_nv !== 1 || w_addr !== '0 || w_dout !== exp_word(0))
            $display("FAIL rst_restart got n=%0d %h@%0d want %h@0", w_nv, w_dout, w_addr, exp_word(0));
        else passes++;
        for (int i = 1; i <= 5; i++) tick_win(4);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [1:0] m;
            int         len, idx, nt;
            bit         cont, play;
            case ($urandom_range(0, 2))
                0:       m = 2'd0;
                1:       m = 2'd1;
                default: m = 2'd3;
            endcase
            cont = (m == 2'd1);
            len  = int'($urandom_range(0, 20));
            for (int k = 0; k < 6; k++)
                wr(int'($urandom_range(0, NUM_CHAN - 1)), int'($urandom_range(0, len)), DATA_W'($urandom));
            start_run(m, len);
            idx  = 0;
            play = 1'b1;
            nt   = cont ? 2 * len + 3 : len + 3;
            for (int k = 0; k < nt; k++) begin
                tick_win(int'($urandom_range(2, 5)));
                checks++;
                if (play) begin
                    if (w_nv !== 1 || w_addr !== ADDR_W'(idx) || w_dout !== exp_word(idx) ||
                        w_nd !== ((idx == len && !cont) ? 1 : 0) || w_done_ok !== 1'b1)
                        $display("FAIL rnd r=%0d k=%0d got n=%0d %h@%0d d=%0d want %h@%0d", r, k, w_nv, w_dout, w_addr, w_nd, exp_word(idx), idx);
                    else passes++;
                    if (idx == len) begin
                        idx = 0;
                        if (!cont) play = 1'b0;
                    end else begin
                        idx++;
                    end
                end else begin
                    if (w_nv !== 0) $display("FAIL rnd_idle r=%0d k=%0d got %0d strobes want 0", r, k, w_nv);
                    else passes++;
                end
            end
            if (cont) abort_clean();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        fill_tables();
        test_oneshot();
        test_continuous();
        test_len_zero();
        test_triggered();
        test_abort();
        test_collision();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
